int_branch_resolver: RTL

INT_BRANCH_RESOLVER -- requirements
Module: int_branch_resolver

---
 rtl/int_branch_resolver.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/int_branch_resolver.sv
// Integer branch resolver: registers per-lane branch results, raises a single
// recovery request for the oldest retiring mispredict, and queues every
// retiring branch into a predictor-update FIFO.
module int_branch_resolver #(
    parameter int unsigned LANES      = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PC_W       = 32,
    parameter int unsigned ALPTR_W    = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       clear,
    input  logic [LANES-1:0]           flush_i,
    input  logic [LANES-1:0]           br_valid_i,
    input  logic [LANES-1:0]           br_mispred_i,
    input  logic [LANES-1:0]           br_taken_i,
    input  logic [LANES-1:0]           br_is_cond_i,
    input  logic [LANES*PC_W-1:0]      br_addr_i,
    input  logic [LANES*PC_W-1:0]      br_next_i,
    input  logic [LANES*ALPTR_W-1:0]   br_alptr_i,
    input  logic [ALPTR_W-1:0]         al_head_i,
    output logic                       rec_req_o,
    output logic [ALPTR_W-1:0]         rec_ptr_o,
    output logic [PC_W-1:0]            rec_target_o,
    input  logic                       rec_ack_i,
    output logic                       upd_valid_o,
    input  logic                       upd_ready_i,
    output logic [PC_W-1:0]            upd_pc_o,
    output logic                       upd_taken_o,
    output logic                       upd_cond_o,
    output logic                       stall_req_o
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LCNT_W = $clog2(LANES + 1);

    typedef enum logic {StIdle, StReq} state_e;

    // Stage register
    logic [LANES-1:0]         valid_q, valid_d;
    logic [LANES-1:0]         mispred_q, mispred_d;
    logic [LANES-1:0]         taken_q, taken_d;
    logic [LANES-1:0]         cond_q, cond_d;
    logic [LANES*PC_W-1:0]    addr_q, addr_d;
    logic [LANES*PC_W-1:0]    next_q, next_d;
    logic [LANES*ALPTR_W-1:0] alptr_q, alptr_d;
    logic [LANES-1:0]         retire;

    // Recovery FSM
    state_e                   state_q, state_d;
    logic [ALPTR_W-1:0]       rec_ptr_q, rec_ptr_d;
    logic [PC_W-1:0]          rec_tgt_q, rec_tgt_d;
    logic                     mp_found;
    logic [ALPTR_W-1:0]       mp_age;
    logic [ALPTR_W-1:0]       mp_ptr;
    logic [PC_W-1:0]          mp_tgt;
    logic [ALPTR_W-1:0]       lane_age;
    logic [ALPTR_W-1:0]       pend_age;

    // Update FIFO
    logic [PC_W-1:0]          mem_pc    [FIFO_DEPTH];
    logic                     mem_taken [FIFO_DEPTH];
    logic                     mem_cond  [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [LCNT_W-1:0]        push_cnt;
    logic [PTR_W-1:0]         wr_idx    [LANES];
    logic                     pop;

    // Stage capture when not stalled; clear and flush kill the incoming lane
    always_comb begin
        valid_d   = valid_q;
        mispred_d = mispred_q;
        taken_d   = taken_q;
        cond_d    = cond_q;
        addr_d    = addr_q;
        next_d    = next_q;
        alptr_d   = alptr_q;
        if (!stall) begin
            valid_d   = br_valid_i & ~flush_i & ~{LANES{clear}};
            mispred_d = br_mispred_i;
            taken_d   = br_taken_i;
            cond_d    = br_is_cond_i;
            addr_d    = br_addr_i;
            next_d    = br_next_i;
            alptr_d   = br_alptr_i;
        end
    end

    // A held lane retires only on the cycle the stall drops
    assign retire = valid_q & {LANES{~stall}};

    // Find the oldest retiring mispredict; ties go to the lower lane
    always_comb begin
        mp_found = 1'b0;
        mp_age   = '0;
        mp_ptr   = '0;
        mp_tgt   = '0;
        lane_age = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_age = alptr_q[l*ALPTR_W +: ALPTR_W] - al_head_i;
            if (retire[l] && mispred_q[l] && (!mp_found || (lane_age < mp_age))) begin
                mp_found = 1'b1;
                mp_age   = lane_age;
                mp_ptr   = alptr_q[l*ALPTR_W +: ALPTR_W];
                mp_tgt   = next_q[l*PC_W +: PC_W];
            end
        end
    end

    assign pend_age = rec_ptr_q - al_head_i;

    // Recovery FSM next state: latch, replace-if-older, or release on ack
    always_comb begin
        state_d   = state_q;
        rec_ptr_d = rec_ptr_q;
        rec_tgt_d = rec_tgt_q;
        if (clear) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (mp_found) begin
                        state_d   = StReq;
                        rec_ptr_d = mp_ptr;
                        rec_tgt_d = mp_tgt;
                    end
                end
                StReq: begin
                    if (rec_ack_i) begin
                        if (mp_found) begin
                            rec_ptr_d = mp_ptr;
                            rec_tgt_d = mp_tgt;
                        end else begin
                            state_d = StIdle;
                        end
                    end else if (mp_found && (mp_age < pend_age)) begin
                        rec_ptr_d = mp_ptr;
                        rec_tgt_d = mp_tgt;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Pack retiring lanes into consecutive FIFO slots, lower lane first
    always_comb begin
        push_cnt = '0;
        for (int l = 0; l < LANES; l++) begin
            wr_idx[l] = wr_ptr_q + PTR_W'(push_cnt);
            if (retire[l]) begin
                push_cnt = push_cnt + LCNT_W'(1);
            end
        end
    end

    assign pop = upd_valid_o & upd_ready_i;

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push_cnt) - CNT_W'(pop);
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= '0;
            mispred_q <= '0;
            taken_q   <= '0;
            cond_q    <= '0;
            addr_q    <= '0;
            next_q    <= '0;
            alptr_q   <= '0;
            state_q   <= StIdle;
            rec_ptr_q <= '0;
            rec_tgt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            mispred_q <= mispred_d;
            taken_q   <= taken_d;
            cond_q    <= cond_d;
            addr_q    <= addr_d;
            next_q    <= next_d;
            alptr_q   <= alptr_d;
            state_q   <= state_d;
            rec_ptr_q <= rec_ptr_d;
            rec_tgt_q <= rec_tgt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // FIFO storage; contents are only meaningful under count_q
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (retire[l]) begin
                mem_pc[wr_idx[l]]    <= addr_q[l*PC_W +: PC_W];
                mem_taken[wr_idx[l]] <= taken_q[l];
                mem_cond[wr_idx[l]]  <= cond_q[l];
            end
        end
    end

    assign rec_req_o    = (state_q == StReq);
    assign rec_ptr_o    = rec_ptr_q;
    assign rec_target_o = rec_tgt_q;

    assign upd_valid_o  = (count_q != '0);
    assign upd_pc_o     = mem_pc[rd_ptr_q];
    assign upd_taken_o  = mem_taken[rd_ptr_q];
    assign upd_cond_o   = mem_cond[rd_ptr_q];

    // Request back-pressure once a full cycle of pushes might not fit
    assign stall_req_o  = ((int'(FIFO_DEPTH) - int'(count_q)) < int'(LANES));

endmodule
